// File: rtl/apb_cpu_core.sv
// apb_cpu_core: 16-bit multicycle RISC CPU, sole APB master of a unified RAM.
// Ports: clk, reset (sync, active-high); APB master paddr/pwrite/psel/penable/
// pwdata out, prdata/pready in. Optional debug ports under CPU_DBG_PORT_EN:
// dbg_sel in, dbg_reg/dbg_pc/dbg_fetch out.
module apb_cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
`ifdef CPU_DBG_PORT_EN
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_reg,
  output logic [15:0] dbg_pc,
  output logic        dbg_fetch,
`endif
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [15:0] pwdata,
  input  logic [15:0] prdata,
  input  logic        pready
);

  typedef enum logic [2:0] {
    RST_S, FETCH_S, FETCH_A, EXEC, MEM_S, MEM_A
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_BNE  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_regs [8];

  logic [2:0]  w_op, w_ra, w_rb, w_rc;
  logic [15:0] w_imm, w_a, w_b, w_c;
  logic [15:0] w_pc1, w_ea, w_res, w_npc;
  logic        w_we, w_mem;

  assign w_op  = r_ir[15:13];
  assign w_ra  = r_ir[12:10];
  assign w_rb  = r_ir[9:7];
  assign w_rc  = r_ir[6:4];
  assign w_imm = {{9{r_ir[6]}}, r_ir[6:0]};
  // r0 is never written, so reading it always yields 0
  assign w_a   = r_regs[w_ra];
  assign w_b   = r_regs[w_rb];
  assign w_c   = r_regs[w_rc];
  assign w_pc1 = r_pc + 16'd1;
  assign w_ea  = w_b + w_imm;
  assign w_mem = (w_op == OP_LW) || (w_op == OP_SW);

  always_comb begin
    w_res = 16'h0000;
    w_npc = w_pc1;
    w_we  = 1'b1;
    unique case (w_op)
      OP_ADD:  w_res = w_b + w_c;
      OP_ADDI: w_res = w_ea;
      OP_SUB:  w_res = w_b - w_c;
      OP_NAND: w_res = ~(w_b & w_c);
      OP_BNE: begin
        w_we = 1'b0;
        if (w_a != w_b) w_npc = w_pc1 + w_imm;
      end
      OP_JALR: begin
        w_res = w_pc1;
        w_npc = w_ea;
      end
      default: w_we = 1'b0;
    endcase
  end

  // APB outputs are registered: each transition sets them for the
  // phase being entered. RST_S keeps the bus idle until reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RST_S;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= 16'h0000;
      pwdata  <= 16'h0000;
    end else begin
      unique case (r_state)
        RST_S: begin
          psel    <= 1'b1;
          penable <= 1'b0;
          pwrite  <= 1'b0;
          paddr   <= r_pc;
          r_state <= FETCH_S;
        end
        FETCH_S: begin
          penable <= 1'b1;
          r_state <= FETCH_A;
        end
        FETCH_A: begin
          if (pready) begin
            r_ir    <= prdata;
            psel    <= 1'b0;
            penable <= 1'b0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          psel <= 1'b1;
          if (w_mem) begin
            paddr  <= w_ea;
            pwrite <= (w_op == OP_SW);
            if (w_op == OP_SW) pwdata <= w_a;
            r_state <= MEM_S;
          end else begin
            if (w_we && w_ra != 3'd0) r_regs[w_ra] <= w_res;
            r_pc    <= w_npc;
            paddr   <= w_npc;
            pwrite  <= 1'b0;
            r_state <= FETCH_S;
          end
        end
        MEM_S: begin
          penable <= 1'b1;
          r_state <= MEM_A;
        end
        MEM_A: begin
          if (pready) begin
            if (w_op == OP_LW && w_ra != 3'd0)
              r_regs[w_ra] <= prdata;
            r_pc    <= w_pc1;
            paddr   <= w_pc1;
            pwrite  <= 1'b0;
            penable <= 1'b0;
            r_state <= FETCH_S;
          end
        end
        default: r_state <= RST_S;
      endcase
    end
  end

`ifdef CPU_DBG_PORT_EN
  assign dbg_reg   = r_regs[dbg_sel];
  assign dbg_pc    = r_pc;
  assign dbg_fetch = (r_state == FETCH_S);
`endif

endmodule

// File: tb/tb_apb_cpu_core.sv
// tb_apb_cpu_core: self-checking bench for apb_cpu_core.
// ISA-level reference model predicts every APB transfer.
module tb_apb_cpu_core;

  typedef struct packed {
    logic        f;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } xfer_t;

  logic        clk;
  logic        reset;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;

  logic [15:0] ram   [0:65535];
  logic [15:0] m_mem [0:65535];
  logic [15:0] m_reg [8];
  logic [15:0] m_pc;
  xfer_t       exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

`ifdef CPU_DBG_PORT_EN
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg_reg;
  logic [15:0] dbg_pc;
  logic        dbg_fetch;
`endif

  apb_cpu_core dut (
`ifdef CPU_DBG_PORT_EN
    .dbg_sel  (dbg_sel),
    .dbg_reg  (dbg_reg),
    .dbg_pc   (dbg_pc),
    .dbg_fetch(dbg_fetch),
`endif
    .clk    (clk),
    .reset  (reset),
    .paddr  (paddr),
    .pwrite (pwrite),
    .psel   (psel),
    .penable(penable),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign prdata = ram[paddr];

  function automatic logic [15:0] wrap16(int v);
    return 16'(((v % 65536) + 65536) % 65536);
  endfunction

  function automatic void setr(logic [2:0] r, logic [15:0] v);
    if (r != 3'd0) m_reg[r] = v;
  endfunction

  function automatic void push(logic f, logic wr,
                               logic [15:0] a, logic [15:0] d);
    exp_q.push_back('{f, wr, a, d});
  endfunction

  // One instruction at ISA level; queues the transfers it causes.
  function automatic void model_step();
    logic [15:0] ir, a, b, c, pc1, ea;
    logic [2:0]  op, ra;
    int          simm;
    ir = m_mem[m_pc];
    push(1'b1, 1'b0, m_pc, ir);
    op   = ir[15:13];
    ra   = ir[12:10];
    a    = m_reg[ra];
    b    = m_reg[ir[9:7]];
    c    = m_reg[ir[6:4]];
    simm = ir[6] ? int'(ir[6:0]) - 128 : int'(ir[6:0]);
    pc1  = wrap16(int'(m_pc) + 1);
    ea   = wrap16(int'(b) + simm);
    m_pc = pc1;
    case (op)
      3'd0: setr(ra, wrap16(int'(b) + int'(c)));
      3'd1: setr(ra, ea);
      3'd2: setr(ra, wrap16(int'(b) - int'(c)));
      3'd3: setr(ra, 16'hFFFF ^ (b & c));
      3'd4: if (a != b) m_pc = wrap16(int'(pc1) + simm);
      3'd5: begin
        push(1'b0, 1'b0, ea, m_mem[ea]);
        setr(ra, m_mem[ea]);
      end
      3'd6: begin
        push(1'b0, 1'b1, ea, a);
        m_mem[ea] = a;
      end
      default: begin
        setr(ra, pc1);
        m_pc = ea;
      end
    endcase
  endfunction

  // APB slave + observer: inserts 0..wmax wait states, returns
  // the next completed transfer and the cycle it completed in.
  task automatic wait_xfer(input int wmax, output logic wr,
                           output logic [15:0] a, output logic [15:0] d,
                           output int t, output bit to);
    int waits = 0;
    to = 1'b1; wr = 1'b0; a = '0; d = '0; t = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (psel && !penable) begin
        waits = $urandom_range(wmax, 0);
      end else if (psel && penable) begin
        if (waits > 0) begin
          pready = 1'b0;
          waits--;
        end else begin
          pready = 1'b1;
          wr = pwrite; a = paddr; d = pwdata; t = cyc_cnt;
          to = 1'b0;
          if (pwrite) ram[paddr] = pwdata;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({psel, penable, pwrite, paddr, pwdata} !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_idle: got sel=%b en=%b wr=%b a=%h d=%h, want all 0",
                 psel, penable, pwrite, paddr, pwdata);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_first_setup: got sel=%b en=%b wr=%b a=%h, want 1 0 0 0000",
               psel, penable, pwrite, paddr);
    end
    @(negedge clk);
    n_checks++;
    if ({psel, penable, paddr} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_first_access: got sel=%b en=%b a=%h, want 1 1 0000",
               psel, penable, paddr);
    end
  endtask

  task automatic test_directed();
    xfer_t e;
    logic wr;
    logic [15:0] a, d;
    int t, prev_t;
    bit to, have_prev, prev_mem;
    reset = 1'b1;
    pready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    ram[0]  = 16'h2420; ram[1]  = 16'h2807; ram[2]  = 16'h0CA0;
    ram[3]  = 16'h50A0; ram[4]  = 16'h341F; ram[5]  = 16'h7950;
    ram[6]  = 16'h8400; ram[7]  = 16'h8004; ram[11] = 16'hD836;
    ram[12] = 16'hB87F; ram[13] = 16'hE010;
    ram[14] = 16'h2FFF; ram[15] = 16'h2FFF;
    ram[16] = 16'hC438; ram[17] = 16'hC832; ram[18] = 16'hCC33;
    ram[19] = 16'hD034; ram[20] = 16'hD435; ram[21] = 16'hD836;
    ram[16'hFFFF] = 16'h000F;
    exp_q.delete();
    for (int i = 0; i <= 13; i++) begin
      push(1'b1, 1'b0, 16'(i), 16'h0);
      if (i == 11) push(1'b0, 1'b1, 16'h0036, 16'hFFF8);
      if (i == 12) push(1'b0, 1'b0, 16'hFFFF, 16'h0);
    end
    push(1'b1, 1'b0, 16'd16, 16'h0); push(1'b0, 1'b1, 16'h0038, 16'h0020);
    push(1'b1, 1'b0, 16'd17, 16'h0); push(1'b0, 1'b1, 16'h0032, 16'h0007);
    push(1'b1, 1'b0, 16'd18, 16'h0); push(1'b0, 1'b1, 16'h0033, 16'h0027);
    push(1'b1, 1'b0, 16'd19, 16'h0); push(1'b0, 1'b1, 16'h0034, 16'h0019);
    push(1'b1, 1'b0, 16'd20, 16'h0); push(1'b0, 1'b1, 16'h0035, 16'h001F);
    push(1'b1, 1'b0, 16'd21, 16'h0); push(1'b0, 1'b1, 16'h0036, 16'h000F);
    @(negedge clk);
    reset = 1'b0;
    have_prev = 1'b0; prev_mem = 1'b0; prev_t = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_xfer(0, wr, a, d, t, to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL directed_timeout: no transfer, want addr %h", e.addr);
        return;
      end
      if (wr !== e.wr || a !== e.addr || (e.wr && d !== e.data)) begin
        n_fail++;
        $display("FAIL directed_xfer: got wr=%b a=%h d=%h, want wr=%b a=%h d=%h",
                 wr, a, d, e.wr, e.addr, e.data);
      end
      if (e.f) begin
        if (have_prev) begin
          n_checks++;
          if (t - prev_t != (prev_mem ? 5 : 3)) begin
            n_fail++;
            $display("FAIL directed_latency: fetch %h got %0d clk, want %0d",
                     e.addr, t - prev_t, prev_mem ? 5 : 3);
          end
        end
        have_prev = 1'b1; prev_t = t; prev_mem = 1'b0;
      end else begin
        prev_mem = 1'b1;
      end
    end
  endtask

  task automatic test_random(input int n_instr, input int wmax);
    xfer_t e;
    logic wr;
    logic [15:0] a, d;
    int t, prev_t, nx, cur;
    bit to, have_prev;
    reset = 1'b1;
    pready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'($urandom);
      m_mem[i] = ram[i];
    end
    for (int r = 0; r < 8; r++) m_reg[r] = 16'h0000;
    m_pc = 16'h0000;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    have_prev = 1'b0; prev_t = 0; nx = 1;
    for (int n = 0; n < n_instr; n++) begin
      model_step();
      cur = exp_q.size();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        wait_xfer(wmax, wr, a, d, t, to);
        n_checks++;
        if (to) begin
          n_fail++;
          $display("FAIL random_timeout: instr %0d, want addr %h", n, e.addr);
          return;
        end
        if (wr !== e.wr || a !== e.addr || (e.wr && d !== e.data)) begin
          n_fail++;
          $display("FAIL random_xfer: instr %0d got wr=%b a=%h d=%h, want wr=%b a=%h d=%h",
                   n, wr, a, d, e.wr, e.addr, e.data);
        end
        if (e.f && wmax == 0 && have_prev) begin
          n_checks++;
          if (t - prev_t != (nx == 2 ? 5 : 3)) begin
            n_fail++;
            $display("FAIL random_latency: instr %0d got %0d clk, want %0d",
                     n, t - prev_t, nx == 2 ? 5 : 3);
          end
        end
        if (e.f) begin
          have_prev = 1'b1;
          prev_t = t;
        end
      end
      nx = cur;
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] ea [3];
    logic [15:0] ed [3];
    logic        ew [3];
    logic [15:0] a0, d0, a, d;
    logic        w0, wr;
    int          t;
    bit          found, to;
    ea[0] = 16'h0000; ew[0] = 1'b0; ed[0] = 16'h0000;
    ea[1] = 16'h0001; ew[1] = 1'b0; ed[1] = 16'h0000;
    ea[2] = 16'h0038; ew[2] = 1'b1; ed[2] = 16'h0020;
    reset = 1'b1;
    pready = 1'b1;
    repeat (2) @(negedge clk);
    ram[0] = 16'h2420; ram[1] = 16'hC438; ram[2] = 16'h0000;
    reset = 1'b0;
    for (int x = 0; x < 3; x++) begin
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge clk);
        found = psel && !penable;
      end
      n_checks++;
      if (!found || paddr !== ea[x] || pwrite !== ew[x] ||
          (ew[x] && pwdata !== ed[x])) begin
        n_fail++;
        $display("FAIL wait_setup: xfer %0d got a=%h wr=%b d=%h, want a=%h wr=%b d=%h",
                 x, paddr, pwrite, pwdata, ea[x], ew[x], ed[x]);
      end
      a0 = paddr; w0 = pwrite; d0 = pwdata;
      pready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== a0 ||
            pwrite !== w0 || pwdata !== d0) begin
          n_fail++;
          $display("FAIL wait_hold: xfer %0d cyc %0d got sel=%b en=%b a=%h wr=%b d=%h, want 1 1 %h %b %h",
                   x, k, psel, penable, paddr, pwrite, pwdata, a0, w0, d0);
        end
        if (k == 3) pready = 1'b1;
      end
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = psel && !penable;
    end
    pready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!found || psel !== 1'b1 || penable !== 1'b1 || paddr !== 16'h0002) begin
      n_fail++;
      $display("FAIL abort_pre: got sel=%b en=%b a=%h, want 1 1 0002",
               psel, penable, paddr);
    end
    reset = 1'b1;
    ram[0] = 16'hC438;
    @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL abort_reset: got sel=%b en=%b wr=%b a=%h d=%h, want all 0",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge clk);
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_held: got sel=%b en=%b, want 0 0", psel, penable);
    end
    reset = 1'b0;
    pready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL abort_refetch: got sel=%b en=%b wr=%b a=%h, want 1 0 0 0000",
               psel, penable, pwrite, paddr);
    end
    wait_xfer(0, wr, a, d, t, to);
    wait_xfer(0, wr, a, d, t, to);
    n_checks++;
    if (to || wr !== 1'b1 || a !== 16'h0038 || d !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_regs_clear: got to=%b wr=%b a=%h d=%h, want 0 1 0038 0000",
               to, wr, a, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    test_reset();
    test_directed();
    test_random(400, 0);
    test_random(400, 3);
    test_wait_states();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
